// File: rtl/topk_running_min.sv
// Streaming K-best selector: keeps the K smallest (dist, idx) samples of a query
// in ascending order and emits the sorted list on a one-cycle strobe.
module topk_running_min #(
    parameter int DIST_WIDTH = 25,
    parameter int IDX_WIDTH  = 9,
    parameter int K          = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      restart,
    input  logic                      in_valid,
    input  logic [DIST_WIDTH-1:0]     in_dist,
    input  logic [IDX_WIDTH-1:0]      in_idx,
    input  logic                      finalize,
    output logic                      out_valid,
    output logic [K*DIST_WIDTH-1:0]   out_dist,
    output logic [K*IDX_WIDTH-1:0]    out_idx,
    output logic [K-1:0]              out_entry_valid,
    output logic [CNT_WIDTH-1:0]      out_count,
    output logic                      protocol_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                state;
    logic [K-1:0]          vld_q;
    logic [DIST_WIDTH-1:0] dist_q [K];
    logic [IDX_WIDTH-1:0]  idx_q  [K];
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [K-1:0]          base_vld, le, nx_vld;
    logic [DIST_WIDTH-1:0] base_dist [K];
    logic [DIST_WIDTH-1:0] nx_dist   [K];
    logic [IDX_WIDTH-1:0]  base_idx  [K];
    logic [IDX_WIDTH-1:0]  nx_idx    [K];
    logic [CNT_WIDTH-1:0]  cnt_base, cnt_nx;

    logic open_eff, accept, fin_ok, err_now;

    // restart opens a query in the same cycle, so it legalises in_valid/finalize
    assign open_eff = (state == ACCUM) || restart;
    assign accept   = in_valid && open_eff;
    assign fin_ok   = finalize && open_eff;
    assign err_now  = (in_valid || finalize) && !open_eff;

    always_comb begin
        base_vld = '0;
        le       = '0;
        for (int unsigned i = 0; i < K; i++) begin
            base_vld[i]  = restart ? 1'b0 : vld_q[i];
            base_dist[i] = restart ? '1   : dist_q[i];
            base_idx[i]  = restart ? '0   : idx_q[i];
            le[i]        = base_vld[i] && (base_dist[i] <= in_dist);
        end
        nx_vld = base_vld;
        for (int unsigned i = 0; i < K; i++) begin
            nx_dist[i] = base_dist[i];
            nx_idx[i]  = base_idx[i];
        end
        // valid entries are sorted and contiguous, so le is a prefix mask:
        // entries before it stay, the first slot past it takes the sample, the rest shift
        if (accept) begin
            if (!le[0]) begin
                nx_vld[0]  = 1'b1;
                nx_dist[0] = in_dist;
                nx_idx[0]  = in_idx;
            end
            for (int unsigned i = 1; i < K; i++) begin
                if (!le[i]) begin
                    if (le[i-1]) begin
                        nx_vld[i]  = 1'b1;
                        nx_dist[i] = in_dist;
                        nx_idx[i]  = in_idx;
                    end else begin
                        nx_vld[i]  = base_vld[i-1];
                        nx_dist[i] = base_dist[i-1];
                        nx_idx[i]  = base_idx[i-1];
                    end
                end
            end
        end
        cnt_base = restart ? '0 : cnt_q;
        cnt_nx   = cnt_base;
        if (accept && (cnt_base != '1)) begin
            cnt_nx = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vld_q           <= '0;
            cnt_q           <= '0;
            out_valid       <= 1'b0;
            out_dist        <= '1;
            out_idx         <= '0;
            out_entry_valid <= '0;
            out_count       <= '0;
            protocol_err    <= 1'b0;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i] <= '1;
                idx_q[i]  <= '0;
            end
        end else begin
            vld_q <= nx_vld;
            cnt_q <= cnt_nx;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i] <= nx_dist[i];
                idx_q[i]  <= nx_idx[i];
            end
            if (fin_ok) begin
                state <= EMIT;
            end else if (restart) begin
                state <= ACCUM;
            end else if (state == EMIT) begin
                state <= IDLE;
            end
            out_valid <= fin_ok;
            if (fin_ok) begin
                out_entry_valid <= nx_vld;
                out_count       <= cnt_nx;
                for (int unsigned i = 0; i < K; i++) begin
                    out_dist[i*DIST_WIDTH +: DIST_WIDTH] <= nx_dist[i];
                    out_idx[i*IDX_WIDTH +: IDX_WIDTH]    <= nx_idx[i];
                end
            end
            if (err_now) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_topk_running_min.sv
// Bench for topk_running_min: directed and random queries checked against a
// sorted-queue reference of the K best samples.
module tb_topk_running_min;

    localparam int DW = 25;
    localparam int IW = 9;
    localparam int KK = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n, restart, in_valid, finalize;
    logic [DW-1:0]   in_dist;
    logic [IW-1:0]   in_idx;
    logic            out_valid, protocol_err;
    logic [KK*DW-1:0] out_dist;
    logic [KK*IW-1:0] out_idx;
    logic [KK-1:0]   out_entry_valid;
    logic [CW-1:0]   out_count;

    topk_running_min #(.DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(KK), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid),
        .in_dist(in_dist), .in_idx(in_idx), .finalize(finalize),
        .out_valid(out_valid), .out_dist(out_dist), .out_idx(out_idx),
        .out_entry_valid(out_entry_valid), .out_count(out_count),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {int d; int ix;} samp_t;

    samp_t q[$];
    int    m_cnt;
    bit    m_open;
    bit    m_err;
    int    nvec;
    int    nfail;

    logic [KK*DW-1:0] exp_dist;
    logic [KK*IW-1:0] exp_idx;
    logic [KK-1:0]    exp_vld;
    logic [CW-1:0]    exp_cnt;

    function automatic void model_reset();
        q.delete();
        m_cnt  = 0;
        m_open = 0;
        m_err  = 0;
    endfunction

    // Stable insertion: a new sample goes behind every kept sample with dist <= it.
    function automatic void model_insert(int d, int ix);
        int    pos;
        samp_t s;
        pos = 0;
        foreach (q[j]) if (q[j].d <= d) pos = j + 1;
        s.d = d;
        s.ix = ix;
        q.insert(pos, s);
        if (q.size() > KK) void'(q.pop_back());
        if (m_cnt < 65535) m_cnt++;
    endfunction

    function automatic void snapshot();
        logic [31:0] t;
        exp_dist = '1;
        exp_idx  = '0;
        exp_vld  = '0;
        foreach (q[j]) begin
            t = q[j].d;
            exp_dist[j*DW +: DW] = t[DW-1:0];
            t = q[j].ix;
            exp_idx[j*IW +: IW] = t[IW-1:0];
            exp_vld[j] = 1'b1;
        end
        t = m_cnt;
        exp_cnt = t[CW-1:0];
    endfunction

    // Drives one cycle of inputs and advances the reference alongside it.
    task automatic step(input logic r, input logic v, input int d, input int ix, input logic f);
        logic [31:0] t;
        bit open_eff;
        restart  = r;
        in_valid = v;
        finalize = f;
        t = d;
        in_dist = t[DW-1:0];
        t = ix;
        in_idx = t[IW-1:0];
        open_eff = m_open || r;
        if ((v || f) && !open_eff) m_err = 1;
        if (r) begin
            q.delete();
            m_cnt = 0;
        end
        if (v && open_eff) model_insert(d, ix);
        if (f && open_eff) begin
            snapshot();
            m_open = 0;
        end else if (r) begin
            m_open = 1;
        end
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        finalize = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        restart = 1'b0; in_valid = 1'b0; finalize = 1'b0; in_dist = '0; in_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nvec++;
        if ({out_valid, protocol_err, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b0, 1'b0, {(KK*DW){1'b1}}, {(KK*IW){1'b0}}, {KK{1'b0}}, {CW{1'b0}}}) begin
            nfail++;
            $display("FAIL reset_state: got v=%b err=%b dist=%h idx=%h ev=%b cnt=%0d, want all ones dist, rest zero",
                     out_valid, protocol_err, out_dist, out_idx, out_entry_valid, out_count);
        end
    endtask

    task automatic test_basic_sort();
        step(1, 1, 50, 1, 0);
        step(0, 1, 30, 2, 0);
        step(0, 1, 70, 3, 0);
        step(0, 1, 10, 4, 0);
        step(0, 1, 40, 5, 1);
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, DW'(50), DW'(40), DW'(30), DW'(10), IW'(1), IW'(5), IW'(2), IW'(4), 4'b1111, CW'(5)}) begin
            nfail++;
            $display("FAIL basic_sort: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want dist {10,30,40,50} idx {4,2,5,1} cnt 5",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count);
        end
        step(0, 0, 0, 0, 0);
        nvec++;
        if (out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL basic_strobe_width: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_ties_underfill();
        step(1, 1, 20, 7, 0);
        step(0, 1, 20, 8, 0);
        step(0, 0, 0, 0, 1);
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, {DW{1'b1}}, {DW{1'b1}}, DW'(20), DW'(20), IW'(0), IW'(0), IW'(8), IW'(7), 4'b0011, CW'(2)}) begin
            nfail++;
            $display("FAIL ties_underfill: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want dist {20,20,max,max} idx {7,8,0,0} ev 0011 cnt 2",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        step(1, 1, 5, 11, 0);
        step(0, 1, 6, 12, 0);
        step(0, 0, 0, 0, 1);
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, exp_dist, exp_idx, exp_vld, exp_cnt}) begin
            nfail++;
            $display("FAIL b2b_query_a: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want dist=%h idx=%h ev=%b cnt=%0d",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count, exp_dist, exp_idx, exp_vld, exp_cnt);
        end
        step(1, 1, 9, 3, 0);
        step(0, 0, 0, 0, 1);
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, DW'(9), IW'(0), IW'(0), IW'(0), IW'(3), 4'b0001, CW'(1)}) begin
            nfail++;
            $display("FAIL b2b_query_b: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want dist {9,max..} idx {3,0..} cnt 1",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_mid_restart();
        step(1, 1, 3, 1, 0);
        step(0, 1, 4, 2, 0);
        step(0, 1, 5, 3, 0);
        step(1, 1, 100, 1, 0);
        step(0, 0, 0, 0, 1);
        nvec++;
        if ({out_valid, protocol_err, out_dist, out_entry_valid, out_count} !==
            {1'b1, 1'b0, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, DW'(100), 4'b0001, CW'(1)}) begin
            nfail++;
            $display("FAIL mid_restart: got v=%b err=%b dist=%h ev=%b cnt=%0d, want dist {100,max,max,max} cnt 1 err 0",
                     out_valid, protocol_err, out_dist, out_entry_valid, out_count);
        end
        // restart, sample and finalize together from an open query
        step(1, 1, 42, 9, 0);
        step(0, 1, 1, 2, 0);
        step(1, 1, 77, 6, 1);
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, DW'(77), IW'(0), IW'(0), IW'(0), IW'(6), 4'b0001, CW'(1)}) begin
            nfail++;
            $display("FAIL triple_same_cycle: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want only (77,6) cnt 1",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int n;
        bit fin_with_last;
        for (int qn = 0; qn < 40; qn++) begin
            n = $urandom_range(1, 12);
            fin_with_last = $urandom_range(0, 1);
            step(1, 1, $urandom_range(0, 15), $urandom_range(0, 511), (n == 1) && fin_with_last);
            for (int s = 1; s < n; s++) begin
                step(($urandom_range(0, 9) == 0), 1, $urandom_range(0, 15), $urandom_range(0, 511),
                     (s == n - 1) && fin_with_last);
            end
            if (!fin_with_last) step(0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 511), 1);
            nvec++;
            if ({out_valid, protocol_err, out_dist, out_idx, out_entry_valid, out_count} !==
                {1'b1, 1'b0, exp_dist, exp_idx, exp_vld, exp_cnt}) begin
                nfail++;
                $display("FAIL random_q%0d: got v=%b err=%b dist=%h idx=%h ev=%b cnt=%0d, want dist=%h idx=%h ev=%b cnt=%0d",
                         qn, out_valid, protocol_err, out_dist, out_idx, out_entry_valid, out_count,
                         exp_dist, exp_idx, exp_vld, exp_cnt);
            end
            if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_protocol_err();
        step(0, 1, 1, 1, 0);
        nvec++;
        if ({out_valid, protocol_err} !== {1'b0, 1'b1}) begin
            nfail++;
            $display("FAIL perr_valid_idle: got v=%b err=%b, want v=0 err=1", out_valid, protocol_err);
        end
        step(0, 0, 0, 0, 1);
        nvec++;
        if ({out_valid, protocol_err} !== {1'b0, 1'b1}) begin
            nfail++;
            $display("FAIL perr_finalize_idle: got v=%b err=%b, want v=0 err=1", out_valid, protocol_err);
        end
        repeat (3) step(0, 0, 0, 0, 0);
        nvec++;
        if ({out_valid, protocol_err} !== {1'b0, m_err}) begin
            nfail++;
            $display("FAIL perr_sticky: got v=%b err=%b, want v=0 err=%b", out_valid, protocol_err, m_err);
        end
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, {(KK*DW){1'b1}}, {(KK*IW){1'b0}}, {KK{1'b0}}, {CW{1'b0}}}) begin
            nfail++;
            $display("FAIL perr_list_clear: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want empty list cnt 0",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_saturation();
        step(1, 1, 12, 1, 0);
        step(0, 1, 13, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({out_valid, protocol_err, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b0, 1'b0, {(KK*DW){1'b1}}, {(KK*IW){1'b0}}, {KK{1'b0}}, {CW{1'b0}}}) begin
            nfail++;
            $display("FAIL async_reset: got v=%b err=%b dist=%h idx=%h ev=%b cnt=%0d, want reset values",
                     out_valid, protocol_err, out_dist, out_idx, out_entry_valid, out_count);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0);
        nvec++;
        if ({out_valid, protocol_err} !== 2'b00) begin
            nfail++;
            $display("FAIL reset_no_emit: got v=%b err=%b, want 0 0", out_valid, protocol_err);
        end
        step(1, 1, 100000, 0, 0);
        for (int i = 1; i <= 65538; i++) begin
            step(0, 1, 100000 - i, i % 512, i == 65538);
        end
        nvec++;
        if ({out_valid, out_dist, out_idx, out_entry_valid, out_count} !==
            {1'b1, exp_dist, exp_idx, exp_vld, exp_cnt} || exp_cnt !== 16'hFFFF) begin
            nfail++;
            $display("FAIL saturation: got v=%b dist=%h idx=%h ev=%b cnt=%0d, want dist=%h idx=%h ev=%b cnt=65535",
                     out_valid, out_dist, out_idx, out_entry_valid, out_count, exp_dist, exp_idx, exp_vld);
        end
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        test_reset();
        test_basic_sort();
        test_ties_underfill();
        test_back_to_back();
        test_mid_restart();
        test_random();
        test_protocol_err();
        test_reset_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/topk_running_min.md
# topk_running_min

Streaming K-nearest selector sitting directly downstream of the L2 distance kernel in the ANN search datapath. For each query it accepts one (distance, candidate-index) sample per cycle while the main controller sweeps leaf memory, and keeps the K smallest distances in ascending order. When the controller marks the end of the query, it emits the sorted K-best list with a one-cycle valid pulse to the next stage.

## Interface
- DIST_WIDTH, 25: width of the unsigned squared-L2 distance.
- IDX_WIDTH, 9: candidate index width ({leaf address, slot within leaf}).
- K, 4: number of best candidates kept; legal range is 1 to 8.
- CNT_WIDTH, 16: width of the sample counter.
---
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- restart  in  1  starts a new query and clears the list.
- in_valid  in  1  a sample is present this cycle.
- in_dist  in  DIST_WIDTH  sample distance, unsigned.
- in_idx  in  IDX_WIDTH  sample candidate index.
- finalize  in  1  ends the query; the result is emitted on the next cycle.
- out_valid  out  1  one-cycle result strobe.
- out_dist  out  K x DIST_WIDTH  sorted distances; entry 0 is the smallest.
- out_idx  out  K x IDX_WIDTH  indices matching out_dist.
- out_entry_valid  out  K  per-entry occupied flag.
- out_count  out  CNT_WIDTH  number of samples accepted in the emitted query, saturating.
- protocol_err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- FSM states:
  - IDLE: no query is open.
  - ACCUM: a query is open and samples are accepted.
  - EMIT: one cycle, drives out_valid.
- Transitions:
  - IDLE to ACCUM on restart.
  - ACCUM to EMIT on finalize.
  - EMIT to IDLE, or to ACCUM if restart is high in that cycle.
  - restart in ACCUM clears the list and the counter and stays in ACCUM.
- Each list entry holds {vld, dist, idx}. A clear sets vld=0, dist=all ones, idx=0.
- Insertion, done in a single cycle on an accepted sample:
  - p = count of valid entries with dist <= in_dist. Ties keep the earlier sample ahead of the new one.
  - Entries at positions p..K-2 shift down one place. The old entry K-1 is dropped.
  - The new sample is written at position p.
  - If p == K, the list is unchanged.
- A sample is accepted when in_valid is high and either the state is ACCUM or restart is high.
- restart and in_valid in the same cycle: the list is cleared first, then the sample is inserted at entry 0 and the count becomes 1.
- finalize and in_valid in the same cycle: the sample is included in the emitted result.
- restart, in_valid and finalize all in the same cycle: the result contains only that sample, with count 1.
- Sample counter: increments on each accepted sample and saturates at 2^CNT_WIDTH - 1.
- protocol_err is set by any of:
  - in_valid in IDLE or EMIT without restart. The sample is dropped.
  - finalize in IDLE or EMIT. It is ignored.
- Output registers load only on the cycle that enters EMIT. They hold their value until the next emission.

## Timing
- Reset values:
  - state is IDLE.
  - All list entries are cleared.
  - out_valid=0 and protocol_err=0.
  - out_dist is all ones; out_idx and out_entry_valid are 0; out_count=0.
- The list register reflects a sample one cycle after acceptance.
- out_valid rises exactly 1 cycle after the finalize cycle and lasts 1 cycle.
- Back-to-back queries are supported: restart may be asserted in the EMIT cycle with no bubble.
- Reset asserted mid-query: everything returns to reset values immediately. No emission occurs.
- Throughput is one sample per clock. There is no backpressure; the downstream stage must take out_valid when it is presented.

## Test plan
- **Basic sort.** K=4. restart with (dist 50, idx 1), then (30,2), (70,3), (10,4), (40,5), with finalize on the last. Required: out_valid 1 cycle later; dist={10,30,40,50}; idx={4,2,5,1}; count=5.
- **Ties and underfill.** restart with (20,7), then (20,8), then finalize. Required: dist={20,20,max,max}; idx={7,8,0,0}; out_entry_valid=4'b0011; count=2.
- **Back-to-back queries.** Query A = {5,6}, finalize. restart with (9,3) in the EMIT cycle, then finalize. Required: A is emitted; then B is emitted with dist={9,...} and count=1, with no lost sample.
- **Mid-query restart.** Accept 3 samples; restart together with (100,1); then finalize. Required: dist={100,max,max,max}; count=1; protocol_err=0.
- **Protocol errors.** in_valid in IDLE, then finalize in IDLE. Required: protocol_err=1 and sticky; no out_valid; the list stays cleared.
- **Reset and saturation.** Assert rst_n low during ACCUM. Required: outputs go to reset values asynchronously. Then stream 2^16+3 samples of decreasing distance. Required: count=65535; list holds the 4 smallest.
